// File: rtl/ahb_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_sequencer
// Purpose  : Turns one burst command plus a write-data stream into an INCR
//            NONSEQ/SEQ/BUSY/IDLE beat sequence for the AHB master pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_sequencer #(
  parameter int WDT = 32
) (
  input  logic           i_hclk,
  input  logic           i_hreset_n,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic [31:0]    i_cmd_addr,
  input  logic [7:0]     i_cmd_len,
  input  logic [1:0]     i_cmd_size,
  input  logic           i_cmd_write,
  input  logic [3:0]     i_cmd_prot,
  input  logic           i_cmd_lock,
  input  logic           i_wr_valid,
  output logic           o_wr_ready,
  input  logic [WDT-1:0] i_wr_data,
  input  logic           i_hready,
  input  logic           i_hgrant,
  input  logic [1:0]     i_hresp,
  output logic [31:0]    o_haddr,
  output logic [1:0]     o_htrans,
  output logic [1:0]     o_hsize,
  output logic [3:0]     o_hprot,
  output logic           o_hwrite,
  output logic           o_hlock,
  output logic           o_hbusreq,
  output logic [WDT-1:0] o_hwdata,
  output logic           o_done,
  output logic           o_err,
  output logic [1:0]     o_err_resp
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_XFER  = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;

  localparam logic [1:0] c_TR_IDLE   = 2'd0;
  localparam logic [1:0] c_TR_BUSY   = 2'd1;
  localparam logic [1:0] c_TR_NONSEQ = 2'd2;
  localparam logic [1:0] c_TR_SEQ    = 2'd3;

  logic [1:0]  r_state;
  logic [8:0]  r_rem;
  logic        r_restart;
  logic        r_hold;

  logic [1:0]  w_cmd_size;
  logic [31:0] w_cmd_inc;
  logic [31:0] w_cmd_addr_al;
  logic [31:0] w_next_addr;
  logic [8:0]  w_drain_cnt;
  logic        w_adv;
  logic        w_err;
  logic        w_beat;
  logic        w_need;

  generate
    if (WDT == 32) begin : g_size_clamp
      assign w_cmd_size = (i_cmd_size == 2'd3) ? 2'd2 : i_cmd_size;
    end else begin : g_size_pass
      assign w_cmd_size = i_cmd_size;
    end
  endgenerate

  assign w_cmd_inc     = 32'd1 << w_cmd_size;
  assign w_cmd_addr_al = i_cmd_addr & ~(w_cmd_inc - 32'd1);
  assign w_next_addr   = o_haddr + (32'd1 << o_hsize);
  assign w_adv         = i_hready & i_hgrant;
  assign w_err         = (i_hresp != 2'd0) & ~i_hready;
  assign w_beat        = (o_htrans == c_TR_NONSEQ) | (o_htrans == c_TR_SEQ);
  // r_hold marks a write word already popped for a beat the slave has not taken
  assign w_drain_cnt   = r_rem - {8'd0, r_hold};

  assign w_need = ((o_htrans == c_TR_IDLE) & r_restart & ~r_hold) |
                  (o_htrans == c_TR_BUSY) |
                  (w_beat & (r_rem != 9'd1));

  assign o_cmd_ready = (r_state == c_S_IDLE);
  assign o_wr_ready  = (r_state == c_S_DRAIN) |
                       ((r_state == c_S_XFER) & o_hwrite & w_adv & w_need);

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      r_state    <= c_S_IDLE;
      r_rem      <= 9'd0;
      r_restart  <= 1'b0;
      r_hold     <= 1'b0;
      o_haddr    <= 32'd0;
      o_htrans   <= c_TR_IDLE;
      o_hsize    <= 2'd0;
      o_hprot    <= 4'd0;
      o_hwrite   <= 1'b1;
      o_hlock    <= 1'b0;
      o_hbusreq  <= 1'b0;
      o_hwdata   <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_resp <= 2'd0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (w_err) begin
        o_err      <= 1'b1;
        o_err_resp <= i_hresp;
      end
      case (r_state)
        c_S_IDLE: begin
          if (i_cmd_valid) begin
            o_haddr   <= w_cmd_addr_al;
            o_hsize   <= w_cmd_size;
            o_hprot   <= i_cmd_prot;
            o_hwrite  <= i_cmd_write;
            o_hlock   <= i_cmd_lock;
            o_hbusreq <= 1'b1;
            o_htrans  <= c_TR_IDLE;
            r_rem     <= {1'b0, i_cmd_len} + 9'd1;
            r_restart <= 1'b1;
            r_hold    <= 1'b0;
            r_state   <= c_S_XFER;
          end
        end
        c_S_XFER: begin
          if (w_err) begin
            o_htrans  <= c_TR_IDLE;
            o_hbusreq <= 1'b0;
            o_hlock   <= 1'b0;
            r_hold    <= 1'b0;
            if (o_hwrite && (w_drain_cnt != 9'd0)) begin
              r_rem   <= w_drain_cnt;
              r_state <= c_S_DRAIN;
            end else begin
              r_rem   <= 9'd0;
              r_state <= c_S_IDLE;
            end
          end else if (!i_hgrant) begin
            o_htrans  <= c_TR_IDLE;
            r_restart <= 1'b1;
          end else if (i_hready) begin
            case (o_htrans)
              c_TR_IDLE: begin
                if (r_restart) begin
                  if (!o_hwrite || r_hold) begin
                    o_htrans  <= c_TR_NONSEQ;
                    r_restart <= 1'b0;
                  end else if (i_wr_valid) begin
                    o_htrans  <= c_TR_NONSEQ;
                    o_hwdata  <= i_wr_data;
                    r_hold    <= 1'b1;
                    r_restart <= 1'b0;
                  end
                end
              end
              c_TR_BUSY: begin
                if (i_wr_valid) begin
                  o_htrans <= (o_haddr[9:0] == 10'd0) ? c_TR_NONSEQ : c_TR_SEQ;
                  o_hwdata <= i_wr_data;
                  r_hold   <= 1'b1;
                end
              end
              default: begin
                r_rem   <= r_rem - 9'd1;
                o_haddr <= w_next_addr;
                if (r_rem == 9'd1) begin
                  o_htrans  <= c_TR_IDLE;
                  o_hbusreq <= 1'b0;
                  o_hlock   <= 1'b0;
                  o_done    <= 1'b1;
                  r_hold    <= 1'b0;
                  r_state   <= c_S_IDLE;
                end else if (o_hwrite && !i_wr_valid) begin
                  o_htrans <= c_TR_BUSY;
                  r_hold   <= 1'b0;
                end else begin
                  // a 1 KB crossing must restart the burst with NONSEQ
                  o_htrans <= (w_next_addr[9:0] == 10'd0) ? c_TR_NONSEQ : c_TR_SEQ;
                  if (o_hwrite) begin
                    o_hwdata <= i_wr_data;
                    r_hold   <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        c_S_DRAIN: begin
          if (i_wr_valid) begin
            r_rem <= r_rem - 9'd1;
            if (r_rem == 9'd1) begin
              r_state <= c_S_IDLE;
            end
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ahb_master_sequencer.md
# ahb_master_sequencer

Command-driven burst sequencer that sits directly upstream of the AHB master pipeline and drives its address/control/write-data inputs. It turns one command (start address, beat count, size, direction) plus a write-data stream into a legal INCR-style sequence of NONSEQ/SEQ/BUSY/IDLE beats. It handles bus request, grant loss, 1 KB boundary restarts and error/retry/split termination. Read data is returned by the pipeline's data-in stage, not by this block.

## Interface
- WDT, 32, data bus width; legal values are 32 and 64.

- i_hclk  in  1  clock
- i_hreset_n  in  1  reset, synchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid; combinational, equals (state==IDLE)
- i_cmd_addr  in  32  start address
- i_cmd_len  in  8  beats minus 1 (1..256 beats)
- i_cmd_size  in  2  HSIZE
- i_cmd_write  in  1  1=write
- i_cmd_prot  in  4  HPROT
- i_cmd_lock  in  1  HLOCK for the whole command
- i_wr_valid  in  1  write data present
- o_wr_ready  out  1  write data consumed on valid&ready; combinational
- i_wr_data  in  WDT  write data
- i_hready, i_hgrant  in  1 each  bus status
- i_hresp  in  2  OKAY=0, ERROR=1, RETRY=2, SPLIT=3
- o_haddr  out  32, o_htrans out 2, o_hsize out 2, o_hprot out 4, o_hwrite out 1, o_hlock out 1, o_hbusreq out 1, o_hwdata out WDT  pipeline inputs, all registered
- o_done  out  1  one-cycle pulse when the last beat is accepted
- o_err  out  1  one-cycle pulse on a non-OKAY response
- o_err_resp  out  2  code of the last non-OKAY response; held until the next one

## Operation
- adv = i_hready & i_hgrant. A beat is accepted when adv=1 and o_htrans is NONSEQ(2) or SEQ(3).
- States are IDLE, XFER and DRAIN. Registers: rem (9 bits, beats not yet accepted), restart flag.
- Size clamp: i_cmd_size is clamped to 2 when WDT=32.
- Alignment: the low address bits below the size are cleared at accept.
- Address increment: addr + (1<<size) mod 2^32.
- IDLE, command handshake:
  - latch all command fields; rem = len+1; restart=1.
  - o_hbusreq<=1, o_htrans<=IDLE; go to XFER.
- XFER: o_htrans/o_haddr/o_hwdata update only on adv cycles or when i_hgrant=0.
  - i_hgrant=0: o_htrans<=IDLE, set restart. The pending beat (address, data) is held, not lost.
  - adv while presenting IDLE (restart=1): load the pending beat as NONSEQ and clear restart. For a write this needs data: o_wr_ready=1, and if i_wr_valid=0 stay IDLE.
  - Beat accepted:
    - rem-=1 and addr advances.
    - If rem becomes 0: o_htrans<=IDLE, o_hbusreq<=0, o_hlock<=0, pulse o_done, go to IDLE.
    - Otherwise the next beat is SEQ, or NONSEQ if the new addr[9:0]==0 (1 KB boundary).
    - For a write with i_wr_valid=0, the next beat is BUSY(1) at the next address.
  - adv while presenting BUSY: re-evaluate the same rule (SEQ/NONSEQ if data is available, else BUSY).
  - Write data is popped (o_wr_ready=1) only in the cycle it is loaded into o_hwdata with a NONSEQ/SEQ beat. Reads never assert o_wr_ready.
- Non-OKAY response (i_hresp!=OKAY & i_hready=0, first response cycle), in any state:
  - pulse o_err and latch o_err_resp.
  - In XFER it also aborts: o_htrans<=IDLE, o_hbusreq<=0, o_hlock<=0, no o_done.
    - Write with rem>0: go to DRAIN. Otherwise go to IDLE.
- DRAIN: o_wr_ready=1; each handshake decrements rem; go to IDLE when rem reaches 0.
- Reset values:
  - o_haddr 0, o_htrans IDLE, o_hsize 0, o_hprot 0.
  - o_hwrite 1, o_hlock 0, o_hbusreq 0, o_hwdata 0.
  - o_done 0, o_err 0, o_err_resp 0.
  - state IDLE, rem 0, restart 0.

## Timing
- Command accept at edge N: o_hbusreq=1 from N+1. The first NONSEQ is presented after the first edge with adv=1 (read, or write with data valid in that cycle).
- Back-to-back: with adv=1 every cycle and data always valid, one beat is accepted per cycle. A 4-beat write takes 4 consecutive accepted cycles after NONSEQ is presented.
- Wait states: all outputs are held while i_hready=0 and i_hgrant=1, except the error abort.
- Regrant: at least one IDLE cycle follows regrant before the restart NONSEQ.
- New command: o_cmd_ready is high the cycle after o_done or abort completes.
- Reset: a low i_hreset_n sampled at any edge, including mid-burst, forces all reset values at that edge. No partial state survives.
- Simultaneous events: a non-OKAY response overrides beat acceptance in the same cycle.

## Test plan
- Read, addr=0x100, len=3, size=2, adv always 1 -> NONSEQ 0x100, SEQ 0x104, 0x108, 0x10C; then IDLE, o_done 1 cycle, o_hbusreq 0.
- Write, len=3, i_wr_valid low for 2 cycles after beat 1 -> two BUSY at 0x104, SEQ resumes with the correct data; 4 pops total.
- Read from 0x3F8, len=3, size=2 -> SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
- i_hgrant=0 for 3 cycles after beat 2 of 5 -> IDLE while ungranted, one IDLE after regrant, then NONSEQ at beat-3 address; no beat skipped or duplicated.
- Write len=7, ERROR after beat 3 -> o_err, o_err_resp=1, IDLE next cycle, DRAIN consumes 4 remaining words, no o_done. Repeat with SPLIT -> o_err_resp=3.
- Reset asserted mid-burst -> all outputs at reset values at the next edge; a new command is accepted afterwards.
